// File: rtl/rggen_bit_field_if_driver.sv
// Initiator for the bit-field access interface. Each accepted request produces
// exactly one single-cycle access strobe, and the captured read data goes back
// on a valid/ready response channel. A request with an all-zero mask is
// answered with an error response and no access is made.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request
// ACCESS   | strobe asserted for one cycle; read data captured at its end
// RESPONSE | response held until the consumer accepts it
module rggen_bit_field_if_driver #(
  parameter int WIDTH          = 8,
  parameter bit MASK_READ_DATA = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic [WIDTH-1:0] i_req_mask,
  input  logic [WIDTH-1:0] i_req_data,
  output logic             o_bit_field_valid,
  output logic [WIDTH-1:0] o_bit_field_read_mask,
  output logic [WIDTH-1:0] o_bit_field_write_mask,
  output logic [WIDTH-1:0] o_bit_field_write_data,
  input  logic [WIDTH-1:0] i_bit_field_read_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             write_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_error_q;
  logic             req_accept;
  logic             req_empty_mask;
  logic             rsp_accept;

  assign req_accept     = i_req_valid && (state == IDLE);
  assign req_empty_mask = (i_req_mask == '0);
  assign rsp_accept     = i_rsp_ready && (state == RESPONSE);

  // State register; reset drops any in-flight request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and interface outputs derived from the current state.
  always_comb begin
    state_next             = state;
    o_req_ready            = 1'b0;
    o_bit_field_valid      = 1'b0;
    o_bit_field_read_mask  = '0;
    o_bit_field_write_mask = '0;
    o_bit_field_write_data = '0;
    o_rsp_valid            = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (req_accept) begin
          state_next = req_empty_mask ? RESPONSE : ACCESS;
        end
      end
      ACCESS: begin
        o_bit_field_valid = 1'b1;
        if (write_q) begin
          o_bit_field_write_mask = mask_q;
          o_bit_field_write_data = data_q;
        end else begin
          o_bit_field_read_mask = mask_q;
        end
        state_next = RESPONSE;
      end
      RESPONSE: begin
        o_rsp_valid = 1'b1;
        if (rsp_accept) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
    end else if (req_accept) begin
      write_q <= i_req_write;
      mask_q  <= i_req_mask;
      data_q  <= i_req_data;
    end
  end

  // Response payload: error on empty mask, otherwise read data sampled at the end of ACCESS.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else if (req_accept && req_empty_mask) begin
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b1;
    end else if (state == ACCESS) begin
      rsp_error_q <= 1'b0;
      if (write_q) begin
        rsp_data_q <= '0;
      end else if (MASK_READ_DATA) begin
        rsp_data_q <= i_bit_field_read_data & mask_q;
      end else begin
        rsp_data_q <= i_bit_field_read_data;
      end
    end
  end

  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_error = rsp_error_q;

endmodule
